// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the fetch stage: host program load, fixed-latency reads.
// Optional even-parity protection of stored words is enabled with `define IMEM_PARITY_EN.
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 8
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module imem_fetch_responder #(
  parameter int ADDR_W  = `IMEM_ADDR_WIDTH,
  parameter int INSTR_W = `INSTR_WIDTH,
  parameter int RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               load_done,
  input  logic               host_wr_en,
  input  logic [ADDR_W-1:0]  host_wr_addr,
  input  logic [INSTR_W-1:0] host_wr_data,
  input  logic [ADDR_W-1:0]  addr_out,
  input  logic               valid_out,
  output logic               ready_out,
  output logic [INSTR_W-1:0] data_in,
  output logic               valid_in,
  output logic [ADDR_W-1:0]  addr_in,
  output logic [ADDR_W:0]    instr_count,
  output logic               wr_drop,
  output logic               parity_err
);

  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state_q, state_d;

  logic [INSTR_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic               wr_commit;
  logic               wr_stray;
  logic               enter_load;
  logic               accept;

  logic [RD_LAT-1:0]  pv;
  logic [ADDR_W-1:0]  pa [RD_LAT];
  logic [INSTR_W-1:0] pd [RD_LAT];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (!load_start && load_done) state_d = RUN;
      RUN:     if (load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign ready_out  = (state_q == RUN);
  assign wr_commit  = host_wr_en && (state_q == LOAD);
  assign wr_stray   = host_wr_en && (state_q != LOAD);
  assign enter_load = (state_q != LOAD) && (state_d == LOAD);
  assign accept     = valid_out && ready_out;

  // A dropped write in the same cycle as load entry still leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count <= '0;
      wr_drop     <= 1'b0;
    end else begin
      if (enter_load)
        instr_count <= '0;
      else if (wr_commit && instr_count != COUNT_MAX)
        instr_count <= instr_count + (ADDR_W+1)'(1);
      if (wr_stray)
        wr_drop <= 1'b1;
      else if (enter_load)
        wr_drop <= 1'b0;
    end
  end

  // Storage is deliberately not reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (wr_commit && !rst)
      mem[host_wr_addr] <= host_wr_data;
  end

  // Stage 0 captures the word at acceptance; the last stage is the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pa[i] <= '0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= accept;
      if (accept) begin
        pa[0] <= addr_out;
        pd[0] <= mem[addr_out];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pa[i] <= pa[i-1];
          pd[i] <= pd[i-1];
        end
      end
    end
  end

  assign valid_in = pv[RD_LAT-1];
  assign addr_in  = pa[RD_LAT-1];
  assign data_in  = pd[RD_LAT-1];

`ifdef IMEM_PARITY_EN
  logic mem_par [0:(1<<ADDR_W)-1];
  logic pp [RD_LAT];
  logic err_q;
  logic err_now;

  always_ff @(posedge clk) begin
    if (wr_commit && !rst)
      mem_par[host_wr_addr] <= ^host_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pp[i] <= 1'b0;
    end else begin
      if (accept) pp[0] <= mem_par[addr_out];
      for (int i = 1; i < RD_LAT; i++)
        if (pv[i-1]) pp[i] <= pp[i-1];
    end
  end

  // The check looks at the delivered word so the flag rises with valid_in.
  assign err_now    = valid_in && ((^data_in) != pp[RD_LAT-1]);
  assign parity_err = err_q | err_now;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | err_now;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: directed program load, fetches, reset and saturation cases.
`timescale 1ns/1ps
module tb_imem_fetch_responder;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;
  localparam int RD_LAT  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               load_start, load_done, host_wr_en, valid_out;
  logic [ADDR_W-1:0]  host_wr_addr, addr_out;
  logic [INSTR_W-1:0] host_wr_data;
  logic               ready_out, valid_in, wr_drop, parity_err;
  logic [INSTR_W-1:0] data_in;
  logic [ADDR_W-1:0]  addr_in;
  logic [ADDR_W:0]    instr_count;

  typedef struct {
    logic [ADDR_W-1:0]  a;
    logic [INSTR_W-1:0] d;
    int                 c;
    logic               p;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  logic perr_exp = 1'b0;

  imem_fetch_responder #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_done(load_done),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .addr_out(addr_out), .valid_out(valid_out), .ready_out(ready_out),
    .data_in(data_in), .valid_in(valid_in), .addr_in(addr_in),
    .instr_count(instr_count), .wr_drop(wr_drop), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock of stimulus; an expected response is queued when the request should be accepted.
  task automatic applyStimulus(input logic ls, input logic ld, input logic we,
                               input logic [ADDR_W-1:0] wa, input logic [INSTR_W-1:0] wd,
                               input logic rv, input logic [ADDR_W-1:0] ra,
                               input logic exp_acc, input logic [INSTR_W-1:0] exp_data);
    exp_t x;
    @(negedge clk);
    load_start = ls; load_done = ld; host_wr_en = we; host_wr_addr = wa;
    host_wr_data = wd; valid_out = rv; addr_out = ra;
    @(posedge clk);
    #1;
    if (exp_acc) begin
      x.a = ra; x.d = exp_data; x.c = cyc + RD_LAT - 1; x.p = perr_exp;
      sb.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic readReq(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    applyStimulus(0, 0, 0, 0, 0, 1, a, 1, d);
  endtask

  always @(negedge clk) begin
    if (valid_in === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", {31'd0, valid_in}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("resp_addr", {28'd0, addr_in}, {28'd0, e.a});
        checkOutput("resp_data", {24'd0, data_in}, {24'd0, e.d});
        checkOutput("resp_cycle", cyc, e.c);
        checkOutput("resp_parity", {31'd0, parity_err}, {31'd0, e.p});
      end
    end
  end

  initial begin
    rst = 1'b1; load_start = 0; load_done = 0; host_wr_en = 0; valid_out = 0;
    host_wr_addr = '0; host_wr_data = '0; addr_out = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_ready", {31'd0, ready_out}, 0);
    checkOutput("rst_valid", {31'd0, valid_in}, 0);
    checkOutput("rst_data", {24'd0, data_in}, 0);
    checkOutput("rst_addr", {28'd0, addr_in}, 0);
    checkOutput("rst_count", {27'd0, instr_count}, 0);
    checkOutput("rst_wr_drop", {31'd0, wr_drop}, 0);
    checkOutput("rst_parity", {31'd0, parity_err}, 0);

    // Requests in IDLE and LOAD must be ignored.
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("idle_ready", {31'd0, ready_out}, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("load_ready", {31'd0, ready_out}, 0);
    applyStimulus(0, 0, 1, 0, 8'h11, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 8'h22, 1, 2, 0, 0);
    applyStimulus(0, 0, 1, 2, 8'h33, 1, 3, 0, 0);
    checkOutput("load_count3", {27'd0, instr_count}, 3);
    applyStimulus(0, 1, 1, 3, 8'h44, 1, 0, 0, 0);
    checkOutput("done_count", {27'd0, instr_count}, 4);
    checkOutput("run_ready", {31'd0, ready_out}, 1);

    readReq(0, 8'h11); readReq(1, 8'h22); readReq(2, 8'h33); readReq(3, 8'h44);
    idle(3);

    applyStimulus(0, 0, 1, 1, 8'hFF, 0, 0, 0, 0);
    checkOutput("run_wr_drop", {31'd0, wr_drop}, 1);
    checkOutput("run_wr_count", {27'd0, instr_count}, 4);
    readReq(1, 8'h22);
    idle(3);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reload_wr_drop", {31'd0, wr_drop}, 0);
    checkOutput("reload_count", {27'd0, instr_count}, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("both_ready", {31'd0, ready_out}, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rerun_ready", {31'd0, ready_out}, 1);
    readReq(2, 8'h33); readReq(3, 8'h44);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("leave_run_ready", {31'd0, ready_out}, 0);
    idle(3);

    // An in-flight request is discarded by a reset one edge later; memory survives.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 2, 0, 0);
    @(negedge clk);
    rst = 1'b1; valid_out = 0;
    @(posedge clk); #1;
    checkOutput("midrst_ready", {31'd0, ready_out}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    readReq(2, 8'h33);
    idle(3);

    // Count saturation and write-then-read on the very next edge.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 0, 1, 4'(i), 8'hA0 + 8'(i), 0, 0, 0, 0);
    checkOutput("count_full", {27'd0, instr_count}, 16);
    applyStimulus(0, 1, 1, 0, 8'hB0, 0, 0, 0, 0);
    checkOutput("count_sat", {27'd0, instr_count}, 16);
    readReq(0, 8'hB0); readReq(15, 8'hAF); readReq(5, 8'hA5);
    idle(3);

`ifdef IMEM_PARITY_EN
    dut.mem[2] = dut.mem[2] ^ 8'h01;
    perr_exp = 1'b1;
    readReq(2, 8'hA3);
    idle(3);
    checkOutput("parity_sticky", {31'd0, parity_err}, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    perr_exp = 1'b0;
    checkOutput("parity_rst", {31'd0, parity_err}, 0);
    @(negedge clk);
    rst = 1'b0;
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    checkOutput("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
